oiia_tone_seq: RTL and testbench
================================

# oiia_tone_seq

Frame-synchronous melody sequencer producing the 1-bit `sound` output on `uio_out[7]` of the goose demo top. It consumes the one-cycle frame tick generated at pixel (0,0) by the VGA timing stage. It steps through a fixed 16-step "OIIA" chant ROM and synthesises a square wave whose half-period is derived from each step's period code. The output is mutable, and the sequencer can be restarted from the `ui_in` controls.

## Interface
- `FRAMES_PER_STEP`, default 8: frames each melody step is held; legal range 1..256.
- `TONE_SHIFT`, default 12: half-period in clocks = code << TONE_SHIFT; legal range 1..12.
- `clk` input, 1: pixel clock (25.175 MHz nominal).
- `rst_n` input, 1: reset, asynchronous, active-low.
- `frame_tick` input, 1: one-cycle pulse at the start of each frame.
- `enable` input, 1: level. 1 = play; 0 = stop and rewind.
- `mute` input, 1: level. Forces `sound` low without stopping sequencing.
- `sound` output, 1: square-wave audio.
- `step` output, 4: current melody step index.
- `note_active` output, 1: high while in PLAY and the current code is non-zero.
- `loop_done` output, 1: one-cycle pulse when step wraps from 15 to 0.

## Operation
- Melody ROM, steps 0..15, 4-bit period codes: 6,6,3,3,3,3,0,0,6,6,3,3,2,2,0,0.
- Code 0 is a rest. Codes 1..15 give a half-period of `code << TONE_SHIFT` clocks (16-bit). A larger code gives a lower pitch.
- Registers:
  - `state` (IDLE/PLAY)
  - `step` (4b)
  - `frame_cnt` (8b)
  - `tone_cnt` (16b)
  - `tone_bit` (1b)
  - `loop_done` (1b)
- **IDLE.** `step`=0, `frame_cnt`=0, `tone_cnt`=0, `tone_bit`=0. `frame_tick` with `enable`=1 moves to PLAY. Ticks with `enable`=0 are ignored.
- **PLAY, tone generation.** Each clock with a non-zero code, `tone_cnt` increments. When `tone_cnt` == half_period−1, `tone_cnt`←0 and `tone_bit` toggles. With code 0, `tone_cnt`←0 and `tone_bit`←0.
- **PLAY, stepping.** On `frame_tick`:
  - If `frame_cnt` == FRAMES_PER_STEP−1: `frame_cnt`←0, `step`←`step`+1 (mod 16), `tone_cnt`←0, `tone_bit`←0. If `step` was 15, `loop_done`←1 for one cycle.
  - Otherwise: `frame_cnt`←`frame_cnt`+1.
- **PLAY, stop.** `enable`=0 in any PLAY cycle returns to IDLE next cycle with all registers cleared. This takes priority over a coincident `frame_tick` or a tone toggle.
- **Outputs.**
  - `sound` = `tone_bit` & ~`mute` (combinational gate on a flop).
  - `note_active` = (`state`==PLAY) & (ROM[`step`]≠0).
- Tone phase restarts at every step boundary, even when consecutive codes are equal. This gives an audible re-articulation of "O-I-I-A".

## Timing
- Reset values: `sound`=0, `step`=0, `note_active`=0, `loop_done`=0, `state`=IDLE. Reset is asynchronous assert and synchronous release.
- **Start.** `frame_tick` at cycle T with `enable`=1 in IDLE gives `state`=PLAY at T+1, `step`=0, and `note_active`=1 at T+1. Step 0 has code 6, so the first `tone_bit` rise occurs at T+1+24576.
- **Step advance.** The `frame_tick` that completes a step at cycle T gives the new `step` at T+1. `tone_bit`=0 at T+1. The first toggle of the new note occurs half_period cycles after T+1.
- **Loop.** `loop_done` is high exactly in cycle T+1 after the 15→0 transition. A full loop takes 16×FRAMES_PER_STEP frames.
- **Mute.** `mute` affects `sound` in the same cycle. Counters are unaffected.
- **Mid-note reset.** `rst_n` low mid-note clears `sound` immediately. It is not necessary to wait for a clock edge.
- **FRAMES_PER_STEP=1.** Every tick in PLAY advances `step`.

## Test plan
- **Reset/idle.** Hold `enable`=0 and pulse `frame_tick` 10 times → `step`=0, `sound`=0, `note_active`=0 throughout.
- **First note.** Set `enable`=1 and pulse `frame_tick` at T → `note_active`=1 at T+1. `sound` rises at T+1+24576 and falls 24576 clocks later (TONE_SHIFT=12).
- **Stepping and loop.** Use FRAMES_PER_STEP=2 with 32 ticks:
  - `step` advances every 2nd tick, sequence 0..15.
  - `note_active` is 0 during steps 6, 7, 14 and 15.
  - `loop_done` pulses once, one cycle after the 32nd tick.
  - Step 12 measures a half-period of 8192 clocks.
- **Rest and re-articulation.** At the step 2→3 boundary (both code 3), `tone_bit` is forced to 0 and `tone_cnt` restarts: the next rise comes 12288 clocks after the boundary. During steps 6–7, `sound` stays 0.
- **Mute and stop priority.** Toggle `mute` mid-note → `sound` follows ~`mute`&`tone_bit` combinationally while `step` keeps advancing. Drop `enable` in the same cycle as a step-completing `frame_tick` → IDLE with `step`=0 next cycle and no `loop_done`.
- **Async reset mid-note.** Assert `rst_n`=0 while `sound`=1 → `sound`=0 with no clock edge. After release, `step`=0 and `state`=IDLE.

Source files
------------

// File: rtl/oiia_tone_seq.sv
// rtl/oiia_tone_seq.sv - frame-synchronous 16-step OIIA chant square-wave sequencer
module oiia_tone_seq #(
  parameter int FRAMES_PER_STEP = 8,
  parameter int TONE_SHIFT      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       mute,
  output logic       sound,
  output logic [3:0] step,
  output logic       note_active,
  output logic       loop_done
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_STEP - 1);

  state_t      state;
  logic [7:0]  frame_cnt;
  logic [15:0] tone_cnt;
  logic        tone_bit;
  logic [3:0]  code;
  logic [15:0] half_period;

  function automatic logic [3:0] rom_code(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd8, 4'd9:                   rom_code = 4'd6;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd10, 4'd11:     rom_code = 4'd3;
      4'd12, 4'd13:                             rom_code = 4'd2;
      default:                                  rom_code = 4'd0;
    endcase
  endfunction

  assign code        = rom_code(step);
  assign half_period = {12'd0, code} << TONE_SHIFT;
  assign sound       = tone_bit & ~mute;
  assign note_active = (state == PLAY) && (code != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 4'd0;
      frame_cnt <= 8'd0;
      tone_cnt  <= 16'd0;
      tone_bit  <= 1'b0;
      loop_done <= 1'b0;
    end else begin
      loop_done <= 1'b0;
      case (state)
        IDLE: begin
          step      <= 4'd0;
          frame_cnt <= 8'd0;
          tone_cnt  <= 16'd0;
          tone_bit  <= 1'b0;
          if (frame_tick && enable) state <= PLAY;
        end
        PLAY: begin
          if (!enable) begin
            // stop wins over any coincident step advance or toggle
            state     <= IDLE;
            step      <= 4'd0;
            frame_cnt <= 8'd0;
            tone_cnt  <= 16'd0;
            tone_bit  <= 1'b0;
          end else begin
            if (code == 4'd0) begin
              tone_cnt <= 16'd0;
              tone_bit <= 1'b0;
            end else if (tone_cnt == half_period - 16'd1) begin
              tone_cnt <= 16'd0;
              tone_bit <= ~tone_bit;
            end else begin
              tone_cnt <= tone_cnt + 16'd1;
            end
            if (frame_tick) begin
              if (frame_cnt == FRAME_LAST) begin
                // phase restarts even between equal codes for re-articulation
                frame_cnt <= 8'd0;
                step      <= step + 4'd1;
                tone_cnt  <= 16'd0;
                tone_bit  <= 1'b0;
                if (step == 4'd15) loop_done <= 1'b1;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oiia_tone_seq.sv
// tb/tb_oiia_tone_seq.sv - randomized self-checking bench for oiia_tone_seq
module tb_oiia_tone_seq;

  localparam int F = 2;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic       mute = 1'b0;
  logic       sound;
  logic [3:0] step;
  logic       note_active;
  logic       loop_done;

  oiia_tone_seq #(.FRAMES_PER_STEP(F), .TONE_SHIFT(S)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .mute(mute), .sound(sound), .step(step), .note_active(note_active),
    .loop_done(loop_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int rom [16] = '{6, 6, 3, 3, 3, 3, 0, 0, 6, 6, 3, 3, 2, 2, 0, 0};

  // model: note phase is just the number of cycles since the note began
  bit m_play;
  int m_step, m_frames, m_elapsed;
  bit m_loop;
  int m_loops;

  function automatic bit exp_tone();
    int c;
    if (!m_play) return 1'b0;
    c = rom[m_step];
    if (c == 0) return 1'b0;
    return ((m_elapsed / (c << S)) % 2) == 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_step = 0; m_frames = 0; m_elapsed = 0; m_loop = 0;
  endtask

  task automatic model_clock();
    m_loop = 0;
    if (!m_play) begin
      if (frame_tick && enable) begin
        m_play = 1; m_step = 0; m_frames = 0; m_elapsed = 0;
      end
    end else if (!enable) begin
      model_reset();
    end else begin
      m_elapsed++;
      if (frame_tick) begin
        if (m_frames == F - 1) begin
          m_frames = 0;
          m_loop = (m_step == 15);
          if (m_loop) m_loops++;
          m_step = (m_step + 1) % 16;
          m_elapsed = 0;
        end else begin
          m_frames++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("sound", sound, exp_tone() & ~mute);
    check_eq("step", step, m_step);
    check_eq("note_active", note_active, m_play && rom[m_step] != 0);
    check_eq("loop_done", loop_done, m_loop);
  endtask

  task automatic cycle(input bit t, input bit en, input bit mu);
    @(negedge clk);
    frame_tick = t; enable = en; mute = mu;
    #1 check_outputs();
    @(posedge clk);
    model_clock();
  endtask

  initial begin
    bit mu, en;
    int i;
    model_reset();
    m_loops = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_sound", sound, 0);
    check_eq("reset_step", step, 0);
    check_eq("reset_note", note_active, 0);
    check_eq("reset_loop", loop_done, 0);
    rst_n = 1'b1;

    // idle: ticks with enable low are ignored
    for (int k = 0; k < 10; k++) begin
      cycle(1, 0, 0);
      repeat (4) cycle(0, 0, 0);
    end

    // randomized play with mute toggles and occasional stop
    mu = 0; en = 1;
    for (int k = 0; k < 8000; k++) begin
      if ($urandom_range(0, 39) == 0) mu = ~mu;
      if ($urandom_range(0, 1999) == 0) en = 0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1;
      cycle($urandom_range(0, 39) == 0, en, mu);
    end
    check_eq("loops_seen_gt0", m_loops > 0, 1);

    // stop coincident with a step-completing tick
    i = 0;
    while (i < 3000 && !(m_play && m_frames == F - 1)) begin
      cycle($urandom_range(0, 19) == 0, 1, 0);
      i++;
    end
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check_eq("stop_step", step, 0);
    check_eq("stop_loop", loop_done, 0);

    // async reset while sound is high
    i = 0;
    while (i < 3000 && !exp_tone()) begin
      cycle($urandom_range(0, 39) == 0, 1, 0);
      i++;
    end
    @(negedge clk);
    frame_tick = 0; mute = 0;
    #1 check_eq("pre_reset_sound", sound, 1);
    #1 rst_n = 1'b0;
    #1 check_eq("async_sound", sound, 0);
    check_eq("async_step", step, 0);
    check_eq("async_note", note_active, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle(0, 1, 0);
    cycle(1, 1, 0);
    repeat (40) cycle(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
